store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the store-alignment stage and the single-port data memory. Accepts aligned word stores (word address, byte mask, shifted data) from the M stage, queues them in a small FIFO, and drains them to memory whenever the memory port grants a write, so stores do not stall on a busy port. Merges same-word stores into the youngest entry and flags loads that overlap a pending store so the hazard unit can stall them.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- AW, 30, word-address width (byte address bits [31:2])

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESETn  in  1  asynchronous, active-low reset
- StValid  in  1  M-stage store request
- StAddr  in  AW  word address of store
- StMask  in  4  byte-write mask, already shifted by byte offset
- StData  in  32  write data, already shifted into lane position
- StReady  out  1  buffer can accept a store this cycle
- LdValid  in  1  M-stage load request
- LdAddr  in  AW  word address of load
- LdMask  in  4  bytes read by the load
- LdHazard  out  1  load overlaps a pending store; stall
- MemReq  out  1  head entry valid, write requested
- MemAddr  out  AW  head word address
- MemWrite  out  4  head byte mask; 4'b0000 when MemReq=0
- MemWData  out  32  head data
- MemGnt  in  1  memory accepts the write this cycle
- Count  out  $clog2(DEPTH)+1  occupied entries
- Empty  out  1  Count == 0

## Operation

- Storage: DEPTH entries {addr, mask, data}; head pointer, tail pointer, Count register. Pointers wrap modulo DEPTH.
- StReady = (Count != DEPTH); decoded from registers only, no dependence on MemGnt or St* inputs.
- Accept = StValid && StReady && (StMask != 0). StValid with StMask == 0 is a no-op and is not enqueued.
- Merge: on Accept, if Count > 0, youngest entry (tail−1) addr == StAddr, and the youngest entry is not popped this cycle (it is not the head entry with MemReq && MemGnt): OR mask into entry; for each bit set in StMask, replace that data byte. Count and tail are unchanged.
- Otherwise, Accept writes a new entry at the tail, tail+1, and Count+1.
- Pop = MemReq && MemGnt: head+1, Count−1. The write is committed to memory at that edge.
- Simultaneous push and pop: Count unchanged. A push into an empty buffer is never popped in the same cycle.
- MemReq = !Empty. MemAddr, MemWrite and MemWData come directly from the head entry's registers.
- LdHazard = LdValid && any valid entry has addr == LdAddr and (mask & LdMask) != 0. Evaluated on the current contents only; the store presented in the same cycle is excluded, because the pipeline issues one memory operation per cycle.

## Timing

- Reset values: Count = 0, head = tail = 0, Empty = 1, StReady = 1, MemReq = 0, MemWrite = 0, LdHazard = 0. Entry contents are don't-care.
- Reset asserted mid-operation discards all pending stores immediately, asynchronously.
- Latency: a store accepted at edge N is presented with MemReq = 1 in cycle N+1 if the buffer was empty. The earliest memory commit is edge N+1 with MemGnt = 1.
- MemGnt low: the head is held unchanged indefinitely, and MemAddr, MemWrite and MemWData stay stable while MemReq = 1.
- Full (Count == DEPTH): StReady = 0 even if MemGnt = 1 in the same cycle. StReady rises the cycle after a pop.
- LdHazard is combinational. It drops the cycle after the last overlapping entry pops.
- Order: memory sees writes in acceptance order. Merged bytes take the value of the newer store.

## Structure

- Shared package/header: DEPTH default, AW, and an entry field-layout constant (addr | mask | data widths). The hazard unit and memory wrapper use the same widths.
- One natural sub-module, `sb_match`: a per-entry comparator (addr equality plus mask overlap) instantiated DEPTH times for LdHazard, with a single instance reused for the merge check on the youngest entry.
- Everything else (FIFO pointers, Count, merge datapath) lives in the top module.

## Test plan

- Single store, then drain: StAddr=0x10, StMask=0001, StData=0x000000AB, MemGnt=1 → MemReq high next cycle with MemWrite=0001, MemWData=0x000000AB; Empty=1 after the commit edge.
- Merge: SB to 0x20 mask 0001 data 0x11, then SB to 0x20 mask 0100 data 0x00330000, MemGnt=0 → Count=1, head mask 0101, data 0x00330011.
- Fill and back-pressure: 4 stores to distinct addresses with MemGnt=0 → Count=4, StReady=0. Assert MemGnt for 1 cycle → Count=3, StReady=1 the following cycle. Drain order matches acceptance order.
- Simultaneous push and pop: Count=2, new store plus MemGnt=1 in the same cycle → Count stays 2, head advances, tail advances.
- Load hazard: pending entry 0x30 mask 1100. Load 0x30 mask 0011 → LdHazard=0. Load 0x30 mask 0100 → LdHazard=1. LdHazard clears the cycle after the entry pops.
- Reset mid-drain: Count=3 with MemGnt toggling, pulse RESETn low → Count=0, MemReq=0, StReady=1 immediately; no further memory writes occur.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared widths, entry field layout and byte-merge helper
package store_buffer_pkg;
    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 30;
    localparam int MASK_W   = 4;
    localparam int DATA_W   = 32;
    localparam int DATA_LSB = 0;
    localparam int MASK_LSB = DATA_LSB + DATA_W;
    localparam int ADDR_LSB = MASK_LSB + MASK_W;
    localparam int ENTRY_W  = ADDR_LSB + SB_AW;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_d,
        input logic [DATA_W-1:0] new_d,
        input logic [MASK_W-1:0] m
    );
        logic [DATA_W-1:0] r;
        for (int b = 0; b < MASK_W; b++)
            r[8*b +: 8] = m[b] ? new_d[8*b +: 8] : old_d[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/store_buffer_sb_match.sv
// sb_match: one entry comparator, word address equality plus byte-mask overlap
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int AW = SB_AW
) (
    input  logic              valid,
    input  logic [AW-1:0]     entry_addr,
    input  logic [MASK_W-1:0] entry_mask,
    input  logic [AW-1:0]     addr,
    input  logic [MASK_W-1:0] mask,
    output logic              hit
);
    assign hit = valid && (entry_addr == addr) && |(entry_mask & mask);
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO with youngest-entry merge and load-overlap detection
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW
) (
    input  logic                     CLK,
    input  logic                     RESETn,
    input  logic                     StValid,
    input  logic [AW-1:0]            StAddr,
    input  logic [MASK_W-1:0]        StMask,
    input  logic [DATA_W-1:0]        StData,
    output logic                     StReady,
    input  logic                     LdValid,
    input  logic [AW-1:0]            LdAddr,
    input  logic [MASK_W-1:0]        LdMask,
    output logic                     LdHazard,
    output logic                     MemReq,
    output logic [AW-1:0]            MemAddr,
    output logic [MASK_W-1:0]        MemWrite,
    output logic [DATA_W-1:0]        MemWData,
    input  logic                     MemGnt,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ENTRY_W - SB_AW + AW;

    logic [EW-1:0]    ent [DEPTH];
    logic [PW-1:0]    head, tail, young;
    logic [DEPTH-1:0] valid, hit;
    logic             pop, accept, merge_hit, young_pop, merge, push;

    assign young     = tail - PW'(1);
    assign Empty     = (Count == '0);
    assign StReady   = (Count != CW'(DEPTH));
    assign MemReq    = !Empty;
    assign pop       = MemReq && MemGnt;
    assign accept    = StValid && StReady && |StMask;
    // the youngest entry cannot absorb a store in the cycle it leaves for memory
    assign young_pop = pop && (young == head);
    assign merge     = accept && merge_hit && !young_pop;
    assign push      = accept && !merge;

    assign MemAddr  = ent[head][ADDR_LSB +: AW];
    assign MemWrite = MemReq ? ent[head][MASK_LSB +: MASK_W] : '0;
    assign MemWData = ent[head][DATA_LSB +: DATA_W];
    assign LdHazard = |hit;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign valid[i] = {1'b0, PW'(i) - head} < Count;
        sb_match #(.AW(AW)) u_match (
            .valid(LdValid && valid[i]),
            .entry_addr(ent[i][ADDR_LSB +: AW]),
            .entry_mask(ent[i][MASK_LSB +: MASK_W]),
            .addr(LdAddr),
            .mask(LdMask),
            .hit(hit[i])
        );
    end

    // entry masks are never zero, so an all-ones probe mask reduces this to address equality
    sb_match #(.AW(AW)) u_merge (
        .valid(!Empty),
        .entry_addr(ent[young][ADDR_LSB +: AW]),
        .entry_mask(ent[young][MASK_LSB +: MASK_W]),
        .addr(StAddr),
        .mask('1),
        .hit(merge_hit)
    );

    // FIFO pointers and occupancy
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            head  <= '0;
            tail  <= '0;
            Count <= '0;
        end else begin
            if (pop)
                head <= head + PW'(1);
            if (push)
                tail <= tail + PW'(1);
            Count <= Count + CW'(push) - CW'(pop);
        end
    end

    // entry storage: new entry at tail, or byte merge into the youngest entry
    always_ff @(posedge CLK) begin
        if (push) begin
            ent[tail] <= {StAddr, StMask, StData};
        end else if (merge) begin
            ent[young][MASK_LSB +: MASK_W] <= ent[young][MASK_LSB +: MASK_W] | StMask;
            ent[young][DATA_LSB +: DATA_W] <= merge_bytes(ent[young][DATA_LSB +: DATA_W], StData, StMask);
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with a queue-based reference model checked every cycle
module tb_store_buffer;
    logic        CLK = 0, RESETn = 0;
    logic        StValid = 0, LdValid = 0, MemGnt = 0;
    logic [29:0] StAddr = 0, LdAddr = 0;
    logic [3:0]  StMask = 0, LdMask = 0;
    logic [31:0] StData = 0;
    logic        StReady, LdHazard, MemReq, Empty;
    logic [29:0] MemAddr;
    logic [3:0]  MemWrite;
    logic [31:0] MemWData;
    logic [2:0]  Count;

    int checks = 0, errors = 0;

    store_buffer #(.DEPTH(4), .AW(30)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .StValid(StValid), .StAddr(StAddr), .StMask(StMask), .StData(StData), .StReady(StReady),
        .LdValid(LdValid), .LdAddr(LdAddr), .LdMask(LdMask), .LdHazard(LdHazard),
        .MemReq(MemReq), .MemAddr(MemAddr), .MemWrite(MemWrite), .MemWData(MemWData),
        .MemGnt(MemGnt), .Count(Count), .Empty(Empty)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [29:0] a;
        logic [3:0]  m;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    ent_t t;
    bit   m_pop, m_acc, m_merge;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic bit exp_haz();
        if (!LdValid) return 0;
        foreach (q[i])
            if (q[i].a == LdAddr && (q[i].m & LdMask) != 0) return 1;
        return 0;
    endfunction

    // reference model: a plain queue of pending stores, oldest first
    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            q.delete();
        end else begin
            m_pop   = q.size() > 0 && MemGnt;
            m_acc   = StValid && q.size() < 4 && StMask != 0;
            m_merge = m_acc && q.size() > 0 && q[q.size()-1].a == StAddr && !(m_pop && q.size() == 1);
            if (m_merge) begin
                t = q[q.size()-1];
                t.m = t.m | StMask;
                for (int b = 0; b < 4; b++)
                    if (StMask[b]) t.d[8*b +: 8] = StData[8*b +: 8];
                q[q.size()-1] = t;
            end
            if (m_pop) void'(q.pop_front());
            if (m_acc && !m_merge) begin
                t.a = StAddr; t.m = StMask; t.d = StData;
                q.push_back(t);
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge CLK) begin
        chk("count", 32'(Count), 32'(q.size()));
        chk("empty", 32'(Empty), 32'(q.size() == 0));
        chk("st_ready", 32'(StReady), 32'(q.size() < 4));
        chk("mem_req", 32'(MemReq), 32'(q.size() > 0));
        chk("ld_hazard", 32'(LdHazard), 32'(exp_haz()));
        if (q.size() > 0) begin
            chk("mem_addr", 32'(MemAddr), 32'(q[0].a));
            chk("mem_write", 32'(MemWrite), 32'(q[0].m));
            chk("mem_wdata", MemWData, q[0].d);
        end else begin
            chk("mem_write_idle", 32'(MemWrite), 0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic st_set(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d);
        StValid = 1; StAddr = a; StMask = m; StData = d;
    endtask

    task automatic store(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d);
        st_set(a, m, d);
        tick();
        StValid = 0;
    endtask

    initial begin
        LdValid = 1; LdAddr = 0; LdMask = 4'hF;
        #1;
        chk("rst_count", 32'(Count), 0);
        chk("rst_empty", 32'(Empty), 1);
        chk("rst_ready", 32'(StReady), 1);
        chk("rst_req", 32'(MemReq), 0);
        chk("rst_write", 32'(MemWrite), 0);
        chk("rst_haz", 32'(LdHazard), 0);
        LdValid = 0;
        tick(); tick();
        RESETn = 1;
        tick();

        // single store into empty buffer with grant high: not popped in the same cycle
        MemGnt = 1;
        store(30'h10, 4'b0001, 32'h000000AB);
        chk("single_req", 32'(MemReq), 1);
        chk("single_cnt", 32'(Count), 1);
        chk("single_write", 32'(MemWrite), 32'h1);
        chk("single_data", MemWData, 32'h000000AB);
        chk("single_addr", 32'(MemAddr), 32'h10);
        tick();
        chk("single_drained", 32'(Empty), 1);
        MemGnt = 0;

        // merge into youngest entry
        store(30'h20, 4'b0001, 32'h00000011);
        store(30'h20, 4'b0100, 32'h00330000);
        chk("merge_cnt", 32'(Count), 1);
        chk("merge_mask", 32'(MemWrite), 32'h5);
        chk("merge_data", MemWData, 32'h00330011);

        // fill and back-pressure
        store(30'h21, 4'hF, 32'h21212121);
        store(30'h22, 4'hF, 32'h22222222);
        store(30'h23, 4'hF, 32'h23232323);
        chk("full_cnt", 32'(Count), 4);
        chk("full_ready", 32'(StReady), 0);
        MemGnt = 1;
        st_set(30'h24, 4'hF, 32'h24242424);
        #1;
        chk("full_ready_gnt", 32'(StReady), 0);
        tick();
        StValid = 0; MemGnt = 0;
        chk("after_pop_cnt", 32'(Count), 3);
        chk("after_pop_ready", 32'(StReady), 1);
        chk("after_pop_addr", 32'(MemAddr), 32'h21);

        // simultaneous push and pop
        MemGnt = 1;
        tick();
        chk("pp_pre_cnt", 32'(Count), 2);
        store(30'h40, 4'hF, 32'h40404040);
        chk("pp_cnt", 32'(Count), 2);
        chk("pp_head", 32'(MemAddr), 32'h23);
        tick();
        chk("pp_head2", 32'(MemAddr), 32'h40);
        // same address as the popping sole entry: must become a new entry
        store(30'h40, 4'b0010, 32'h0000BB00);
        chk("nomerge_cnt", 32'(Count), 1);
        chk("nomerge_write", 32'(MemWrite), 32'h2);
        chk("nomerge_data", MemWData, 32'h0000BB00);
        tick();
        chk("nomerge_empty", 32'(Empty), 1);
        MemGnt = 0;

        // load hazard
        store(30'h30, 4'b1100, 32'hDDCC0000);
        LdValid = 1; LdAddr = 30'h30; LdMask = 4'b0011; #1;
        chk("haz_no_overlap", 32'(LdHazard), 0);
        LdMask = 4'b0100; #1;
        chk("haz_overlap", 32'(LdHazard), 1);
        LdAddr = 30'h31; #1;
        chk("haz_other_addr", 32'(LdHazard), 0);
        LdValid = 0; LdAddr = 30'h30; #1;
        chk("haz_no_valid", 32'(LdHazard), 0);
        LdValid = 1; MemGnt = 1;
        tick();
        chk("haz_cleared", 32'(LdHazard), 0);
        chk("haz_empty", 32'(Empty), 1);
        MemGnt = 0;

        // store presented in the same cycle is not a hazard yet
        LdAddr = 30'h50; LdMask = 4'hF;
        st_set(30'h50, 4'hF, 32'h50505050);
        #1;
        chk("haz_same_cycle", 32'(LdHazard), 0);
        tick();
        StValid = 0;
        chk("haz_next_cycle", 32'(LdHazard), 1);
        LdValid = 0;

        // zero-mask store is a no-op
        store(30'h55, 4'b0000, 32'hFFFFFFFF);
        chk("zero_mask_cnt", 32'(Count), 1);

        // reset mid-drain
        store(30'h60, 4'hF, 32'h60606060);
        store(30'h61, 4'hF, 32'h61616161);
        MemGnt = 1; tick();
        MemGnt = 0;
        store(30'h63, 4'hF, 32'h63636363);
        chk("pre_rst_cnt", 32'(Count), 3);
        MemGnt = 1;
        RESETn = 0; #1;
        chk("mid_rst_cnt", 32'(Count), 0);
        chk("mid_rst_req", 32'(MemReq), 0);
        chk("mid_rst_ready", 32'(StReady), 1);
        chk("mid_rst_write", 32'(MemWrite), 0);
        tick();
        RESETn = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_req", 32'(MemReq), 0);
        end
        MemGnt = 0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
